// File: rtl/gtech_glitch_filter_pkg.sv
// rtl/gtech_glitch_filter_pkg.sv - shared constants, state type and clog2 helper for the glitch filter
package gtech_pkg;

  // Per-channel qualification state: IDLE means a_q agrees with Z, QUAL means a change is being timed.
  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } ch_state_e;

  localparam ch_state_e ST_IDLE = IDLE;
  localparam ch_state_e ST_QUAL = QUAL;

  // Number of bits needed to hold values 0..v-1 (at least 1 for v>=2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gtech_glitch_filter_ch.sv
// rtl/gtech_glitch_filter_ch.sv - one deglitch channel: sampler, stability counter, FSM, Z/ZN/CHG regs (GTECH_GLITCH_FILTER_EDGE_EN adds RISE/FALL)
module gtech_glitch_filter_ch
  import gtech_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b1,
  parameter int   CW            = clog2(STABLE_CYCLES + 1)
) (
  input  logic CP,
  input  logic RST,
  input  logic EN,
  input  logic A,
  output logic Z,
  output logic ZN,
  output logic CHG
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
  ,
  output logic RISE,
  output logic FALL
`endif
);

  logic          a_q, a_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ch_state_e     state_q, state_d;
  logic          z_q, z_d;
  logic          zn_q, zn_d;
  logic          chg_q, chg_d;
  logic          commit;
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
`endif

  // Next-state: sample A, time a pending change, and commit it once it has been stable long enough.
  always_comb begin
    a_d     = a_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    z_d     = z_q;
    zn_d    = zn_q;
    chg_d   = 1'b0;
    commit  = 1'b0;
    if (EN) begin
      a_d = A;
      case (state_q)
        ST_IDLE: begin
          if (a_q != z_q) begin
            if (STABLE_CYCLES == 1) begin
              commit = 1'b1;
            end else begin
              cnt_d   = CW'(1);
              state_d = ST_QUAL;
            end
          end
        end
        ST_QUAL: begin
          if (a_q == z_q) begin
            // The sample fell back to the committed level: a glitch, drop the count.
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
      if (commit) begin
        z_d     = a_q;
        zn_d    = ~a_q;
        chg_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
    rise_d = commit & a_q;
    fall_d = commit & ~a_q;
`endif
  end

  // State registers; reset restores the idle level and discards any count in progress.
  always_ff @(posedge CP) begin
    if (RST) begin
      a_q     <= RESET_VAL;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      z_q     <= RESET_VAL;
      zn_q    <= ~RESET_VAL;
      chg_q   <= 1'b0;
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      z_q     <= z_d;
      zn_q    <= zn_d;
      chg_q   <= chg_d;
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign Z   = z_q;
  assign ZN  = zn_q;
  assign CHG = chg_q;
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
  assign RISE = rise_q;
  assign FALL = fall_q;
`endif

endmodule

// File: rtl/gtech_glitch_filter.sv
// rtl/gtech_glitch_filter.sv - WIDTH-channel registered deglitch stage (GTECH_GLITCH_FILTER_EDGE_EN adds RISE/FALL outputs)
module gtech_glitch_filter
  import gtech_pkg::*;
#(
  parameter int   WIDTH         = 1,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b1
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] ZN,
  output logic [WIDTH-1:0] CHG
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  // Reject configurations that cannot qualify anything.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("gtech_glitch_filter: WIDTH must be >= 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
      $error("gtech_glitch_filter: STABLE_CYCLES must be >= 1");
    end
  endgenerate

  // Channels share nothing but clock, reset and enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gtech_glitch_filter_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VAL)
    ) u_ch (
      .CP  (CP),
      .RST (RST),
      .EN  (EN),
      .A   (A[i]),
      .Z   (Z[i]),
      .ZN  (ZN[i]),
      .CHG (CHG[i])
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
      ,
      .RISE(RISE[i]),
      .FALL(FALL[i])
`endif
    );
  end

endmodule

// File: tb/tb_gtech_glitch_filter.sv
// tb/tb_gtech_glitch_filter.sv - scoreboard bench for gtech_glitch_filter (3-ch STABLE_CYCLES=4 and 1-ch STABLE_CYCLES=1)
module tb_gtech_glitch_filter;

  typedef struct {
    int         cyc;
    logic [2:0] z;
    logic [2:0] chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] a0;
  logic [2:0] z0, zn0, chg0;
  logic       a1;
  logic       z1, zn1, chg1;
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
  logic [2:0] rise0, fall0;
  logic       rise1, fall1;
`endif

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  gtech_glitch_filter #(.WIDTH(3), .STABLE_CYCLES(4), .RESET_VAL(1'b1)) dut0 (
    .CP(clk), .RST(rst), .EN(en), .A(a0), .Z(z0), .ZN(zn0), .CHG(chg0)
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
    , .RISE(rise0), .FALL(fall0)
`endif
  );

  gtech_glitch_filter #(.WIDTH(1), .STABLE_CYCLES(1), .RESET_VAL(1'b1)) dut1 (
    .CP(clk), .RST(rst), .EN(en), .A(a1), .Z(z1), .ZN(zn1), .CHG(chg1)
`ifdef GTECH_GLITCH_FILTER_EDGE_EN
    , .RISE(rise1), .FALL(fall1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk0(input int off, input logic [2:0] z, input logic [2:0] chg);
    exp_t e;
    e.cyc = cyc + off;
    e.z   = z;
    e.chg = chg;
    q0.push_back(e);
  endtask

  task automatic chk1(input int off, input logic z, input logic chg);
    exp_t e;
    e.cyc = cyc + off;
    e.z   = {2'b00, z};
    e.chg = {2'b00, chg};
    q1.push_back(e);
  endtask

  // Monitor for the 3-channel instance.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        e = q0.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL dut0 missed check for cyc=%0d (now %0d)", e.cyc, cyc);
      end
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        vectors++;
        if (z0 !== e.z || zn0 !== ~e.z || chg0 !== e.chg) begin
          miscompares++;
          $display("FAIL dut0 cyc=%0d got Z=%b ZN=%b CHG=%b want Z=%b ZN=%b CHG=%b",
                   cyc, z0, zn0, chg0, e.z, ~e.z, e.chg);
        end
      end else if (chg0 !== 3'b000) begin
        vectors++;
        miscompares++;
        $display("FAIL dut0 unexpected CHG cyc=%0d got CHG=%b Z=%b want CHG=000", cyc, chg0, z0);
      end
    end
  end

  // Monitor for the single-cycle-qualify instance.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL dut1 missed check for cyc=%0d (now %0d)", e.cyc, cyc);
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        vectors++;
        if (z1 !== e.z[0] || zn1 !== ~e.z[0] || chg1 !== e.chg[0]) begin
          miscompares++;
          $display("FAIL dut1 cyc=%0d got Z=%b ZN=%b CHG=%b want Z=%b ZN=%b CHG=%b",
                   cyc, z1, zn1, chg1, e.z[0], ~e.z[0], e.chg[0]);
        end
      end else if (chg1 !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL dut1 unexpected CHG cyc=%0d got CHG=%b Z=%b want CHG=0", cyc, chg1, z1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    a0  = 3'b000;
    a1  = 1'b0;
    // Reset: Z=RESET_VAL regardless of A, no CHG.
    chk0(1, 3'b111, 3'b000);
    chk0(2, 3'b111, 3'b000);
    chk1(1, 1'b1, 1'b0);
    chk1(2, 1'b1, 1'b0);
    tick(2);
    rst = 1'b0;
    a0  = 3'b111;
    a1  = 1'b1;
    tick(3);

    // ch0 1->0 held: commit exactly 5 edges after the drive point (capture + 4).
    chk0(4, 3'b111, 3'b000);
    chk0(5, 3'b110, 3'b001);
    chk0(6, 3'b110, 3'b000);
    a0 = 3'b110;
    tick(8);

    chk0(5, 3'b111, 3'b001);
    a0 = 3'b111;
    tick(8);

    // Three-sample low pulse is rejected.
    chk0(5, 3'b111, 3'b000);
    chk0(6, 3'b111, 3'b000);
    a0 = 3'b110;
    tick(3);
    a0 = 3'b111;
    tick(6);

    // Freeze after three enabled edges; count resumes and commits on the second enabled edge.
    chk0(6, 3'b111, 3'b000);
    chk0(9, 3'b111, 3'b000);
    chk0(10, 3'b110, 3'b001);
    chk0(11, 3'b110, 3'b000);
    a0 = 3'b110;
    tick(3);
    en = 1'b0;
    tick(5);
    en = 1'b1;
    tick(6);

    // Multi-channel: single change, all-channel simultaneous change, staggered changes.
    chk0(5, 3'b010, 3'b100);
    a0 = 3'b010;
    tick(8);

    chk0(5, 3'b101, 3'b111);
    chk0(6, 3'b101, 3'b000);
    a0 = 3'b101;
    tick(8);

    chk0(5, 3'b100, 3'b001);
    chk0(6, 3'b100, 3'b000);
    chk0(7, 3'b000, 3'b100);
    a0 = 3'b100;
    tick(2);
    a0 = 3'b000;
    tick(8);

    chk0(5, 3'b111, 3'b111);
    a0 = 3'b111;
    tick(8);

    // STABLE_CYCLES=1: Z follows the sampler one edge later.
    chk1(1, 1'b1, 1'b0);
    chk1(2, 1'b0, 1'b1);
    chk1(3, 1'b0, 1'b0);
    a1 = 1'b0;
    tick(4);
    chk1(2, 1'b1, 1'b1);
    chk1(3, 1'b1, 1'b0);
    a1 = 1'b1;
    tick(4);

    // Reset lands on the edge that would have committed: no change, no CHG.
    chk0(4, 3'b111, 3'b000);
    chk0(5, 3'b111, 3'b000);
    chk0(6, 3'b111, 3'b000);
    chk0(8, 3'b111, 3'b000);
    chk1(5, 1'b1, 1'b0);
    a0 = 3'b010;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    a0  = 3'b111;
    tick(5);

    tick(2);
    while (q0.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL dut0 unchecked entry cyc=%0d", q0[0].cyc);
      void'(q0.pop_front());
    end
    while (q1.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL dut1 unchecked entry cyc=%0d", q1[0].cyc);
      void'(q1.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
